txn_exec_receiver: RTL and testbench

TXN_EXEC_RECEIVER -- requirements
Module: txn_exec_receiver

---
 rtl/txn_exec_receiver_if.sv | 59 +++++
 rtl/txn_exec_receiver.sv | 248 ++++++++++++++++++++++++
 tb/tb_txn_exec_receiver.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/txn_exec_receiver_if.sv
// ---------------------------------------------------------------------------
// txn_exec_receiver_if
// Bundles the three handshakes of the transaction execution receiver:
//   s_axis_*  : AXI-Stream style ingress of scheduled transactions
//   exec_*    : dispatch of a held transaction to the executor
//   done_*    : completion notification from the executor
// Modports:
//   slave  : view of the receiver (consumes s_axis, drives exec, takes done)
//   master : view of the environment around the receiver
// Parameters:
//   MAX_DEPENDENCIES : width of the read/write dependency bitmaps
//   SLOT_W           : width of execution slot indices
// ---------------------------------------------------------------------------
interface txn_exec_receiver_if #(
    parameter int MAX_DEPENDENCIES = 1024,
    parameter int SLOT_W           = 2
);
    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic [63:0]                 s_axis_tdata_owner_programID;
    logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies;
    logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies;

    logic                        exec_valid;
    logic                        exec_ready;
    logic [SLOT_W-1:0]           exec_slot;
    logic [63:0]                 exec_owner_programID;

    logic                        done_valid;
    logic [SLOT_W-1:0]           done_slot;

    modport slave (
        input  s_axis_tvalid,
        output s_axis_tready,
        input  s_axis_tdata_owner_programID,
        input  s_axis_tdata_read_dependencies,
        input  s_axis_tdata_write_dependencies,
        output exec_valid,
        input  exec_ready,
        output exec_slot,
        output exec_owner_programID,
        input  done_valid,
        input  done_slot
    );

    modport master (
        output s_axis_tvalid,
        input  s_axis_tready,
        output s_axis_tdata_owner_programID,
        output s_axis_tdata_read_dependencies,
        output s_axis_tdata_write_dependencies,
        input  exec_valid,
        output exec_ready,
        input  exec_slot,
        input  exec_owner_programID,
        output done_valid,
        output done_slot
    );
endinterface

// File: rtl/txn_exec_receiver.sv
// ---------------------------------------------------------------------------
// txn_exec_receiver
// Receives scheduled transactions into a one-entry hold register, waits until
// an execution slot is free (and, optionally, no lock conflict exists with
// in-flight transactions), then offers the entry to the executor. Tracks
// busy slots, completion events and statistics.
//
// Optional feature macro: TXN_EXEC_LOCK_CHECK_EN
//   defined   : per-slot read/write bitmaps are stored and RAW/WAW/WAR
//               conflicts against busy slots gate dispatch
//   undefined : dispatch is gated only by slot availability
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : s_axis ingress, exec dispatch, done completion
//   txns_received       : saturating count of accepted transactions
//   txns_completed      : saturating count of valid completions
//   stall_cycles        : saturating count of cycles spent in WAIT
//   inflight_count      : number of busy slots
//   protocol_error      : sticky, set by done on a free/out-of-range slot
//
// Hold FSM
//   state    | meaning
//   EMPTY    | hold register empty, ready for a new transaction
//   WAIT     | entry held, no free slot or lock conflict
//   OFFER    | entry offered on exec_*, slot index latched
// ---------------------------------------------------------------------------
module txn_exec_receiver #(
    parameter int MAX_DEPENDENCIES = 1024,
    parameter int NUM_SLOTS        = 4,
    parameter int SLOT_W           = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    txn_exec_receiver_if.slave    bus,
    output logic [31:0]           txns_received,
    output logic [31:0]           txns_completed,
    output logic [31:0]           stall_cycles,
    output logic [SLOT_W:0]       inflight_count,
    output logic                  protocol_error
);

    if (SLOT_W != $clog2(NUM_SLOTS)) begin : g_bad_slot_w
        $error("txn_exec_receiver: SLOT_W must equal clog2(NUM_SLOTS)");
    end

    typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_OFFER} state_t;

    state_t               state, state_nxt;
    logic                 ready_en;
    logic [63:0]          hold_owner;
    logic [SLOT_W-1:0]    offer_slot;
    logic [NUM_SLOTS-1:0] busy;
    logic [NUM_SLOTS-1:0] busy_eval;
    logic [SLOT_W-1:0]    free_slot;
    logic                 free_any;
    logic                 accept;
    logic                 dispatch;
    logic                 done_hit;
    logic                 done_ok;
    logic                 cand_ok;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ready_en keeps s_axis_tready low while reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // ---- FSM: output logic ----
    always_comb begin
        bus.s_axis_tready        = ready_en &&
                                   ((state == ST_EMPTY) ||
                                    ((state == ST_OFFER) && bus.exec_ready));
        bus.exec_valid           = (state == ST_OFFER);
        bus.exec_slot            = offer_slot;
        bus.exec_owner_programID = hold_owner;
    end

    assign accept   = bus.s_axis_tvalid && bus.s_axis_tready;
    assign dispatch = bus.exec_valid && bus.exec_ready;

    // Slot view used for the dispatch decision: the registered busy vector
    // plus any slot taken by this cycle's dispatch. Completions this cycle
    // are deliberately not credited; the freed slot is usable one cycle on.
    always_comb begin
        busy_eval = busy;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (dispatch && (offer_slot == SLOT_W'(i))) busy_eval[i] = 1'b1;
        end
        free_any  = |(~busy_eval);
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy_eval[i]) free_slot = SLOT_W'(i);
        end
    end

`ifdef TXN_EXEC_LOCK_CHECK_EN
    logic [MAX_DEPENDENCIES-1:0] hold_rd, hold_wr;
    logic [MAX_DEPENDENCIES-1:0] cand_rd, cand_wr;
    logic [MAX_DEPENDENCIES-1:0] union_rd, union_wr;
    logic [MAX_DEPENDENCIES-1:0] slot_rd [NUM_SLOTS];
    logic [MAX_DEPENDENCIES-1:0] slot_wr [NUM_SLOTS];
    logic                        conflict;

    // Candidate is the held entry while waiting, otherwise the incoming beat
    always_comb begin
        cand_rd  = (state == ST_WAIT) ? hold_rd : bus.s_axis_tdata_read_dependencies;
        cand_wr  = (state == ST_WAIT) ? hold_wr : bus.s_axis_tdata_write_dependencies;
        union_rd = '0;
        union_wr = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (busy[i]) begin
                union_rd = union_rd | slot_rd[i];
                union_wr = union_wr | slot_wr[i];
            end
        end
        if (dispatch) begin
            union_rd = union_rd | hold_rd;
            union_wr = union_wr | hold_wr;
        end
        conflict = (|(cand_rd & union_wr)) ||
                   (|(cand_wr & union_wr)) ||
                   (|(cand_wr & union_rd));
    end

    assign cand_ok = free_any && !conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_rd <= '0;
            hold_wr <= '0;
        end else if (accept) begin
            hold_rd <= bus.s_axis_tdata_read_dependencies;
            hold_wr <= bus.s_axis_tdata_write_dependencies;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_rd[i] <= '0;
                slot_wr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (dispatch && (offer_slot == SLOT_W'(i))) begin
                    slot_rd[i] <= hold_rd;
                    slot_wr[i] <= hold_wr;
                end else if (done_ok && (bus.done_slot == SLOT_W'(i))) begin
                    slot_rd[i] <= '0;
                    slot_wr[i] <= '0;
                end
            end
        end
    end
`else
    logic unused_deps;
    assign unused_deps = ^{bus.s_axis_tdata_read_dependencies,
                           bus.s_axis_tdata_write_dependencies};
    assign cand_ok     = free_any;
`endif

    // ---- FSM: next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = cand_ok ? ST_OFFER : ST_WAIT;
            ST_WAIT:  if (cand_ok) state_nxt = ST_OFFER;
            ST_OFFER: begin
                if (dispatch) begin
                    if (accept) state_nxt = cand_ok ? ST_OFFER : ST_WAIT;
                    else        state_nxt = ST_EMPTY;
                end
            end
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Slot index is frozen on entry to OFFER so exec_slot stays stable even
    // if a completion frees a lower slot while the offer is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offer_slot <= '0;
            hold_owner <= '0;
        end else begin
            if ((state_nxt == ST_OFFER) && ((state != ST_OFFER) || dispatch))
                offer_slot <= free_slot;
            if (accept)
                hold_owner <= bus.s_axis_tdata_owner_programID;
        end
    end

    // A done index outside the slot range never matches, so it falls out as
    // an error together with done on a free slot.
    always_comb begin
        done_hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if ((bus.done_slot == SLOT_W'(i)) && busy[i]) done_hit = 1'b1;
        end
    end

    assign done_ok = bus.done_valid && done_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (dispatch && (offer_slot == SLOT_W'(i)))
                    busy[i] <= 1'b1;
                else if (done_ok && (bus.done_slot == SLOT_W'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            inflight_count = inflight_count + (SLOT_W+1)'(busy[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txns_received  <= '0;
            txns_completed <= '0;
            stall_cycles   <= '0;
            protocol_error <= 1'b0;
        end else begin
            if (accept)              txns_received  <= sat_inc(txns_received);
            if (done_ok)             txns_completed <= sat_inc(txns_completed);
            if (state == ST_WAIT)    stall_cycles   <= sat_inc(stall_cycles);
            if (bus.done_valid && !done_ok) protocol_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_txn_exec_receiver.sv
module tb_txn_exec_receiver;
    localparam int MD = 1024;
    localparam int NS = 4;
    localparam int SW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] txns_received, txns_completed, stall_cycles;
    logic [SW:0] inflight_count;
    logic        protocol_error;

    always #5 clk = ~clk;

    txn_exec_receiver_if #(.MAX_DEPENDENCIES(MD), .SLOT_W(SW)) bus ();

    txn_exec_receiver #(.MAX_DEPENDENCIES(MD), .NUM_SLOTS(NS), .SLOT_W(SW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .txns_received (txns_received),
        .txns_completed(txns_completed),
        .stall_cycles  (stall_cycles),
        .inflight_count(inflight_count),
        .protocol_error(protocol_error)
    );

    typedef struct packed {
        logic [63:0]   owner;
        logic [SW-1:0] slot;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_dispatch(input logic [63:0] owner, input int slot);
        exp_t e;
        e.owner = owner;
        e.slot  = SW'(slot);
        sb.push_back(e);
    endtask

    // Drive one beat and hold it until the handshake completes (bounded)
    task automatic send(input logic [63:0] owner, input int ri, input int wi);
        logic [MD-1:0] rd, wr;
        logic          accepted;
        rd = '0; wr = '0;
        rd[ri] = 1'b1;
        wr[wi] = 1'b1;
        accepted = 1'b0;
        bus.s_axis_tdata_owner_programID    = owner;
        bus.s_axis_tdata_read_dependencies  = rd;
        bus.s_axis_tdata_write_dependencies = wr;
        bus.s_axis_tvalid = 1'b1;
        for (int n = 0; n < 40 && !accepted; n++) begin
            #1;
            if (bus.s_axis_tready === 1'b1) accepted = 1'b1;
            @(negedge clk);
        end
        bus.s_axis_tvalid = 1'b0;
        chk("send_accepted", 64'(accepted), 64'd1);
    endtask

    // Wait (bounded) for an offer, compare it with the scoreboard, then take it
    task automatic take();
        exp_t e;
        int   n;
        n = 0;
        while ((bus.exec_valid !== 1'b1) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        chk("exec_valid_wait", 64'(bus.exec_valid), 64'd1);
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("exec_slot", 64'(bus.exec_slot), 64'(e.slot));
            chk("exec_owner", bus.exec_owner_programID, e.owner);
        end
        bus.exec_ready = 1'b1;
        @(negedge clk);
        bus.exec_ready = 1'b0;
    endtask

    task automatic done(input int slot);
        bus.done_valid = 1'b1;
        bus.done_slot  = SW'(slot);
        @(negedge clk);
        bus.done_valid = 1'b0;
    endtask

    initial begin
        bus.s_axis_tvalid                   = 1'b0;
        bus.s_axis_tdata_owner_programID    = '0;
        bus.s_axis_tdata_read_dependencies  = '0;
        bus.s_axis_tdata_write_dependencies = '0;
        bus.exec_ready                      = 1'b0;
        bus.done_valid                      = 1'b0;
        bus.done_slot                       = '0;

        // Reset state
        #2;
        chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_exec_valid", 64'(bus.exec_valid), 64'd0);
        chk("rst_inflight", 64'(inflight_count), 64'd0);
        chk("rst_perr", 64'(protocol_error), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", 64'(bus.s_axis_tready), 64'd1);

        // Basic dispatch: owner 1, read bit0 / write bit1
        send(64'd1, 0, 1);
        chk("t1_latency_valid", 64'(bus.exec_valid), 64'd1);
        expect_dispatch(64'd1, 0);
        take();
        chk("t1_inflight", 64'(inflight_count), 64'd1);
        chk("t1_received", 64'(txns_received), 64'd1);

        // Owner 3 reads bit1 which slot0 writes
        send(64'd3, 1, 5);
`ifdef TXN_EXEC_LOCK_CHECK_EN
        chk("t2_wait_valid", 64'(bus.exec_valid), 64'd0);
        chk("t2_stall0", 64'(stall_cycles), 64'd0);
        repeat (3) @(negedge clk);
        chk("t2_stall3", 64'(stall_cycles), 64'd3);
        chk("t2_wait_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("t2_still_wait", 64'(bus.exec_valid), 64'd0);
        done(0);
        chk("t2_completed", 64'(txns_completed), 64'd1);
        chk("t2_not_yet", 64'(bus.exec_valid), 64'd0);
        @(negedge clk);
        chk("t2_offer", 64'(bus.exec_valid), 64'd1);
        chk("t2_stall5", 64'(stall_cycles), 64'd5);
        expect_dispatch(64'd3, 0);
        take();
        done(0);
`else
        chk("t2_immediate", 64'(bus.exec_valid), 64'd1);
        expect_dispatch(64'd3, 1);
        take();
        chk("t2_stall0", 64'(stall_cycles), 64'd0);
        done(0);
        done(1);
`endif
        chk("t2_completed2", 64'(txns_completed), 64'd2);
        chk("t2_inflight0", 64'(inflight_count), 64'd0);

        // Fill all slots with disjoint bitmaps, then a fifth waits for slot 2
        for (int i = 0; i < NS; i++) begin
            send(64'(10 + i), 8 + 2 * i, 9 + 2 * i);
            expect_dispatch(64'(10 + i), i);
            take();
        end
        chk("t3_inflight4", 64'(inflight_count), 64'd4);
        send(64'd20, 30, 31);
        chk("t3_wait_valid", 64'(bus.exec_valid), 64'd0);
        chk("t3_wait_tready", 64'(bus.s_axis_tready), 64'd0);
        done(2);
        expect_dispatch(64'd20, 2);
        take();
        chk("t3_inflight_after", 64'(inflight_count), 64'd4);
        chk("t3_completed", 64'(txns_completed), 64'd3);

        // Back-pressure: owner 7 offered, exec_ready low for five cycles
        done(0);
        send(64'd7, 40, 41);
        for (int k = 0; k < 5; k++) begin
            chk("t4_valid_stable", 64'(bus.exec_valid), 64'd1);
            chk("t4_slot_stable", 64'(bus.exec_slot), 64'd0);
            chk("t4_owner_stable", bus.exec_owner_programID, 64'd7);
            chk("t4_tready_low", 64'(bus.s_axis_tready), 64'd0);
            @(negedge clk);
        end
        expect_dispatch(64'd7, 0);
        take();
        chk("t4_received", 64'(txns_received), 64'd8);
        chk("t4_inflight", 64'(inflight_count), 64'd4);

        // Done on a free slot
        done(3);
        chk("t5_completed5", 64'(txns_completed), 64'd5);
        chk("t5_perr_clear", 64'(protocol_error), 64'd0);
        done(3);
        chk("t5_perr_set", 64'(protocol_error), 64'd1);
        chk("t5_completed_same", 64'(txns_completed), 64'd5);

        // Reset pulse with slots in flight
        rst_n = 1'b0;
        #1;
        chk("r2_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("r2_exec_valid", 64'(bus.exec_valid), 64'd0);
        chk("r2_inflight", 64'(inflight_count), 64'd0);
        chk("r2_received", 64'(txns_received), 64'd0);
        chk("r2_completed", 64'(txns_completed), 64'd0);
        chk("r2_stall", 64'(stall_cycles), 64'd0);
        chk("r2_perr", 64'(protocol_error), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("r2_tready_after", 64'(bus.s_axis_tready), 64'd1);

        // Slot 1 was discarded by reset; completing it is an error
        done(1);
        chk("r2_discarded_perr", 64'(protocol_error), 64'd1);
        chk("r2_discarded_cnt", 64'(txns_completed), 64'd0);
        send(64'd9, 0, 1);
        expect_dispatch(64'd9, 0);
        take();
        chk("r2_inflight1", 64'(inflight_count), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
